// File: rtl/instr_fetch_if.sv
// Instruction fetch bus: synchronous instruction-memory read port plus the
// decode-facing instruction stream with its stall/redirect controls.
interface instr_fetch_if #(
    parameter int PC_W = 10
);
    logic            imem_en;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_rdata;
    logic [8:0]      instr;
    logic            instr_valid;
    logic [PC_W-1:0] pc;
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;

    modport master (
        output imem_en, imem_addr, instr, instr_valid, pc,
        input  imem_rdata, stall, branch_taken, branch_target
    );

    modport slave (
        input  imem_en, imem_addr, instr, instr_valid, pc,
        output imem_rdata, stall, branch_taken, branch_target
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads instruction memory, handles stall,
// taken-branch redirect and HALT. Optional ROE_ICOUNT_EN adds a retired-instruction counter.
module instr_fetch #(
    parameter int         PC_W      = 10,
    parameter logic [8:0] HALT_WORD = 9'h1FF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    output logic            busy,
    output logic            done,
`ifdef ROE_ICOUNT_EN
    output logic [15:0]     icount,
`endif
    instr_fetch_if.master   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic [PC_W-1:0] r_fetch_pc, w_fetch_pc_next;
    logic [PC_W-1:0] r_pc, w_pc_next;
    logic            r_instr_valid, w_instr_valid_next;
    logic            r_done, w_done_next;
    logic            w_imem_en;
    logic            w_halt_hit;
    logic            w_branch_hit;

    assign w_halt_hit   = r_instr_valid && (bus.imem_rdata == HALT_WORD);
    assign w_branch_hit = r_instr_valid && bus.branch_taken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_fetch_pc    <= '0;
            r_pc          <= '0;
            r_instr_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_pc          <= w_pc_next;
            r_instr_valid <= w_instr_valid_next;
            r_done        <= w_done_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_fetch_pc_next    = r_fetch_pc;
        w_pc_next          = r_pc;
        w_instr_valid_next = r_instr_valid;
        w_done_next        = r_done;
        w_imem_en          = 1'b0;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    w_state_next       = S_RUN;
                    w_fetch_pc_next    = start_pc;
                    w_done_next        = 1'b0;
                    w_instr_valid_next = 1'b0;
                end
            end
            S_RUN: begin
                w_imem_en = !bus.stall;
                if (!bus.stall) begin
                    // Halt wins over a branch in the same cycle.
                    if (w_halt_hit) begin
                        w_state_next       = S_HALTED;
                        w_instr_valid_next = 1'b0;
                        w_done_next        = 1'b1;
                    end else if (w_branch_hit) begin
                        // The word read this cycle is wrong-path; drop it as a bubble.
                        w_fetch_pc_next    = bus.branch_target;
                        w_instr_valid_next = 1'b0;
                    end else begin
                        w_pc_next          = r_fetch_pc;
                        w_fetch_pc_next    = r_fetch_pc + PC_W'(1);
                        w_instr_valid_next = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.imem_en     = w_imem_en;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr       = bus.imem_rdata;
    assign bus.instr_valid = r_instr_valid;
    assign bus.pc          = r_pc;
    assign busy            = (r_state == S_RUN);
    assign done            = r_done;

`ifdef ROE_ICOUNT_EN
    logic [15:0] r_icount;
    logic        w_icount_inc;

    assign w_icount_inc = (r_state == S_RUN) && r_instr_valid && !bus.stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_icount <= 16'd0;
        end else if ((r_state != S_RUN) && start) begin
            r_icount <= 16'd0;
        end else if (w_icount_inc && (r_icount != 16'hFFFF)) begin
            r_icount <= r_icount + 16'd1;
        end
    end

    assign icount = r_icount;
`endif
endmodule
